// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

    // Loader session states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    // Byte lanes per 32-bit word need a 2-bit counter.
    localparam int LANE_W = 2;

    // Running XOR checksum starts from zero every session.
    localparam logic [31:0] CHECKSUM_INIT = 32'h0;

    // States in which a session is in progress (busy output).
    function automatic logic is_busy(input state_t s);
        return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) ||
               (s == S_WRITE) || (s == S_CSUM);
    endfunction

    // States in which the loader pulls bytes from the stream.
    function automatic logic is_ready(input state_t s);
        return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: bytes land in lanes 0..3 in arrival order.
// word_out/word_valid are combinational so the consumer can capture the full
// word on the same edge the 4th byte is accepted.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [3:0][7:0]   data_q, data_d;

    // Next lane/data: clear wins, otherwise drop the byte into the current lane.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        lane_d = lane_q;
        data_d = data_q;
        if (clear) begin
            lane_d = '0;
            data_d = '0;
        end else if (byte_valid) begin
            data_d[lane_q] = byte_in;
            lane_d         = lane_q + LANE_W'(1);
        end
    end

    // Lane counter and byte store.
    always_ff @(posedge clk or posedge arst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from pre-edge values.
        if (arst) begin
            lane_q <= '0;
            data_q <= '0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
        end
    end

    // Stored lanes with the byte being accepted overlaid in its lane.
    always_comb begin
        word_out = data_q;
        if (byte_valid) begin
            word_out[8*lane_q +: 8] = byte_in;
        end
        word_valid = byte_valid && (&lane_q);
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives header/count, program words and trailing XOR checksum
// over a byte stream, writes the words into imem and enables the cpu on match.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int MAX_WORDS = 512,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_wen,
    output logic              imem_ren,
    output logic [31:0]       imem_wdata,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam int          ADDR_SHIFT = $clog2(ADDR_STEP);
    localparam logic [15:0] MAX_W16    = 16'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       words_q, words_d;
    logic [31:0]       csum_q, csum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              pk_clear;
    logic [31:0]       pk_word;
    logic              pk_valid;

    assign s_ready = is_ready(state_q);
    assign accept  = s_valid && s_ready;

    byte_packer u_packer (
        .clk        (clk),
        .arst       (arst),
        .clear      (pk_clear),
        .byte_valid (accept),
        .byte_in    (s_data),
        .word_out   (pk_word),
        .word_valid (pk_valid)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        words_d  = words_q;
        csum_d   = csum_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen_d    = 1'b0;
        en_d     = en_q;
        done_d   = done_q;
        err_d    = err_q;
        pk_clear = 1'b0;

        unique case (state_q)
            S_HDR0: begin
                if (accept) state_d = S_HDR1;
            end
            S_HDR1: begin
                if (accept) begin
                    n_d      = pk_word[15:0];
                    pk_clear = 1'b1;  // data phase restarts at lane 0
                    if (pk_word[15:0] > MAX_W16) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (pk_word[15:0] == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (pk_valid) begin
                    state_d = S_WRITE;
                    wdata_d = pk_word;
                    addr_d  = ADDR_W'(words_q) << ADDR_SHIFT;
                    wen_d   = 1'b1;
                end
            end
            S_WRITE: begin
                words_d = words_q + 16'd1;
                csum_d  = csum_q ^ wdata_q;
                state_d = (words_q + 16'd1 == n_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (pk_valid) begin
                    if (pk_word == csum_q) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                        en_d    = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: ;  // IDLE, RUN, ERR wait for start
        endcase

        // A new session may only begin while no session is in progress.
        if (start && !is_busy(state_q)) begin
            state_d  = S_HDR0;
            en_d     = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            words_d  = '0;
            csum_d   = CHECKSUM_INIT;
            pk_clear = 1'b1;
        end

        busy_d = is_busy(state_d);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            words_q <= '0;
            csum_q  <= CHECKSUM_INIT;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            words_q <= words_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign imem_addr    = addr_q;
    assign imem_wen     = wen_q;
    assign imem_ren     = 1'b0;
    assign imem_wdata   = wdata_q;
    assign cpu_enable   = en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [63:0] imem_addr;
    logic        imem_wen;
    logic        imem_ren;
    logic [31:0] imem_wdata;
    logic        cpu_enable;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    // Expected writes and end-of-session results, filled by the model.
    logic [63:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic        exp_done, exp_err;
    int          exp_words;
    logic [7:0]  stream[$];
    logic        prev_wen = 1'b0;

    imem_loader dut (
        .clk          (clk),
        .arst         (arst),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .imem_addr    (imem_addr),
        .imem_wen     (imem_wen),
        .imem_ren     (imem_ren),
        .imem_wdata   (imem_wdata),
        .cpu_enable   (cpu_enable),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: parse a whole session stream by its byte-level rules.
    task automatic model_session(input logic [7:0] b[$]);
        int n;
        logic [31:0] w, cs, rx;
        n = int'(b[0]) | (int'(b[1]) << 8);
        exp_words = 0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        if (n > 512) begin
            exp_err = 1'b1;
            return;
        end
        cs = 32'h0;
        for (int i = 0; i < n; i++) begin
            w = {b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]};
            exp_addr_q.push_back(64'(i) * 64'd4);
            exp_data_q.push_back(w);
            cs ^= w;
        end
        rx = {b[2+4*n+3], b[2+4*n+2], b[2+4*n+1], b[2+4*n]};
        exp_words = n;
        if (rx == cs) exp_done = 1'b1;
        else          exp_err  = 1'b1;
    endtask

    // Build a random program of n words with a correct or corrupted checksum.
    task automatic build_random(input int n, input bit bad);
        logic [31:0] w, cs;
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        cs = 32'h0;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            cs ^= w;
            for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
        end
        if (bad) cs ^= (32'h1 << $urandom_range(0, 31));
        for (int k = 0; k < 4; k++) stream.push_back(cs[8*k +: 8]);
    endtask

    task automatic load_nominal();
        stream = '{8'h02, 8'h00,
                   8'h13, 8'h05, 8'hA0, 8'h00,
                   8'h93, 8'h05, 8'hB0, 8'h00,
                   8'h80, 8'h00, 8'h10, 8'h00};
    endtask

    // One-cycle start pulse; returns #1 after the capturing edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Push bytes through the valid/ready handshake; pct is the s_valid duty.
    task automatic send_bytes(input logic [7:0] b[$], input int pct, input bit mid_start);
        int idx = 0;
        int cyc = 0;
        bit acc;
        bit mid_done = 1'b0;
        while (idx < b.size() && cyc < 4000) begin
            @(negedge clk);
            start = 1'b0;
            if (mid_start && !mid_done && idx == 4) begin
                start    = 1'b1;
                mid_done = 1'b1;
            end
            if ($urandom_range(0, 99) < pct) begin
                s_valid = 1'b1;
                s_data  = b[idx];
            end else begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end
            acc = s_valid && s_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        start   = 1'b0;
        if (idx < b.size()) check("stream_timeout", 64'(idx), 64'(b.size()));
    endtask

    // Wait for the session to end, then compare final status with the model.
    task automatic finish_session(input string tag);
        int cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'(exp_done));
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_cpu_en"}, 64'(cpu_enable), 64'(exp_done));
        check({tag, "_words"}, 64'(words_loaded), 64'(exp_words));
        check({tag, "_writes_left"}, 64'(exp_data_q.size()), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic run_session(input string tag, input int pct, input bit mid_start);
        model_session(stream);
        pulse_start();
        send_bytes(stream, pct, mid_start);
        finish_session(tag);
    endtask

    // Write monitor: every imem_wen cycle must match the next expected write.
    always @(negedge clk) begin
        if (!arst && imem_wen) begin
            check("wen_single_cycle", 64'(prev_wen), 64'd0);
            check("ready_low_in_write", 64'(s_ready), 64'd0);
            check("ren_zero", 64'(imem_ren), 64'd0);
            if (exp_data_q.size() == 0) begin
                check("spurious_wen", 64'(imem_wen), 64'd0);
            end else begin
                check("write_addr", imem_addr, exp_addr_q.pop_front());
                check("write_data", 64'(imem_wdata), 64'(exp_data_q.pop_front()));
            end
        end
        prev_wen <= imem_wen;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  imem_addr, 64'd0);
        check({tag, "_wen"},   64'(imem_wen), 64'd0);
        check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        check({tag, "_cpu_en"}, 64'(cpu_enable), 64'd0);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd0);
        check({tag, "_ready"}, 64'(s_ready), 64'd0);
    endtask

    initial begin
        arst    = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        arst = 1'b0;

        // Nominal program, s_valid held high.
        load_nominal();
        run_session("nominal", 100, 1'b0);
        check("nominal_last_wdata", 64'(imem_wdata), 64'h0000_0000_00B0_0593);
        check("nominal_last_addr", imem_addr, 64'd4);
        check("nominal_words_lit", 64'(words_loaded), 64'd2);
        check("nominal_done_lit", 64'(done), 64'd1);

        // Restart from RUN: enable drops one cycle after start.
        check("pre_restart_en", 64'(cpu_enable), 64'd1);
        pulse_start();
        check("restart_en", 64'(cpu_enable), 64'd0);
        check("restart_words", 64'(words_loaded), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_done", 64'(done), 64'd0);
        build_random(3, 1'b0);
        model_session(stream);
        send_bytes(stream, 100, 1'b0);
        finish_session("restart");

        // Bad checksum: words still written, error raised.
        load_nominal();
        stream[13] = 8'h01;
        run_session("badsum", 100, 1'b0);
        check("badsum_error_lit", 64'(error), 64'd1);
        check("badsum_en_lit", 64'(cpu_enable), 64'd0);

        // Oversize header N=513.
        stream = '{8'h01, 8'h02};
        run_session("oversize", 100, 1'b0);
        check("oversize_error_lit", 64'(error), 64'd1);

        // Empty program.
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_session("empty", 100, 1'b0);
        check("empty_done_lit", 64'(done), 64'd1);

        // Throttled nominal stream with a start injected mid-DATA.
        load_nominal();
        run_session("throttled", 40, 1'b1);

        // Reset after two data bytes: outputs clear at once, nothing written.
        stream = '{8'h02, 8'h00, 8'h13, 8'h05};
        pulse_start();
        send_bytes(stream, 100, 1'b0);
        #2;
        arst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        arst = 1'b0;
        load_nominal();
        run_session("after_reset", 100, 1'b0);

        // Randomized sessions: size, checksum validity and throttling.
        for (int r = 0; r < 12; r++) begin
            build_random($urandom_range(0, 9), ($urandom_range(0, 3) == 0));
            run_session($sformatf("rand%0d", r), $urandom_range(30, 100),
                        bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time loader that sits directly upstream of the cpu top.
- Receives a byte stream over a valid/ready interface, assembles 32-bit instruction words and writes them into instruction memory through the cpu external port (addr_ext/wen_ext/wdata_ext).
- Checks a trailing XOR checksum; on match, raises the cpu enable so the core starts executing from address 0.

Parameters:
- ADDR_W, 64, width of imem_addr; matches cpu addr_ext.
- MAX_WORDS, 512, instruction memory depth in words. A larger header count is an error.
- ADDR_STEP, 4, byte-address increment per written word.

Ports:
- clk  input  1  main clock
- arst  input  1  reset
- start  input  1  one-cycle pulse; begins a load session from IDLE, RUN or ERR
- s_valid  input  1  stream byte valid
- s_data  input  8  stream byte
- s_ready  output  1  loader can accept a byte this cycle
- imem_addr  output  ADDR_W  to cpu addr_ext
- imem_wen  output  1  to cpu wen_ext
- imem_ren  output  1  to cpu ren_ext; constant 0
- imem_wdata  output  32  to cpu wdata_ext
- cpu_enable  output  1  to cpu enable
- busy  output  1  session in progress
- done  output  1  checksum matched; program running
- error  output  1  checksum mismatch or oversize header
- words_loaded  output  16  count of words written this session

Behaviour:
- Clocking and reset: one clock, clk. arst is asynchronous and active-high.
- All outputs are registered except s_ready, which is decoded from state.
- On arst, every output is 0 and the state is IDLE.
- Byte transfer: a byte is accepted when s_valid and s_ready are both high on a rising clk edge.
- States:
  - IDLE: s_ready=0. start moves to HDR0.
  - HDR0: accept the count low byte, then move to HDR1.
  - HDR1: accept the count high byte, giving N[15:0].
    - If N > MAX_WORDS, move to ERR.
    - If N=0, move to CSUM.
    - Otherwise move to DATA.
  - DATA: accept bytes little-endian (first byte is bits 7:0). When the 4th byte is accepted at edge t:
    - imem_wdata gets the word and imem_addr gets words_loaded*ADDR_STEP.
    - imem_wen=1 during cycle t..t+1 (exactly one cycle).
    - State moves to WRITE.
  - WRITE: s_ready=0, imem_wen=1. words_loaded increments and the checksum register XORs in the word.
    - If words_loaded+1 == N, next state is CSUM; otherwise DATA.
    - The next DATA byte can be accepted no earlier than edge t+2.
  - CSUM: accept 4 bytes little-endian and compare with the checksum register.
    - Equal: RUN (done=1, cpu_enable=1 on the following cycle).
    - Not equal: ERR (error=1, cpu_enable stays 0).
  - RUN: s_ready=0. cpu_enable and done stay high until start or arst.
  - ERR: s_ready=0. error stays high until start or arst.
- busy=1 in HDR0, HDR1, DATA, WRITE and CSUM; 0 otherwise.
- imem_wen is 0 in every state except WRITE. imem_addr and imem_wdata hold their last value outside WRITE.
- On start from IDLE, RUN or ERR:
  - Next state is HDR0.
  - cpu_enable, done, error, words_loaded, the checksum register and the byte lane counter all clear on the next edge.
  - cpu_enable therefore drops one cycle after start.
- start while busy=1 is ignored.
- s_valid while s_ready=0 is ignored; the byte is not consumed.
- arst mid-session aborts immediately. No partial word is written; memory contents already written are not restored.
- Arithmetic:
  - The address is a zero-extended product: words_loaded << log2(ADDR_STEP).
  - words_loaded never exceeds MAX_WORDS.
  - The checksum is a 32-bit XOR starting from 0.

Decomposition:
- Shared package/include holds the state encoding (IDLE, HDR0, HDR1, DATA, WRITE, CSUM, RUN, ERR), a lane-count width constant of 2 bits, and CHECKSUM_INIT = 32'h0.
- One sub-module, byte_packer, holds the 2-bit lane counter and 32-bit shift register.
  - Inputs: clk, arst, clear, byte_valid, byte_in.
  - Outputs: word_out and word_valid, pulsing on the 4th byte.
  - It is reused for the header (2 bytes, read via lanes 1:0), data and checksum phases.
- The FSM, counters and checksum live in imem_loader.

Test Plan:
- Nominal load:
  - Stimulus: start; bytes 02 00, 13 05 A0 00, 93 05 B0 00, checksum 80 00 10 00, s_valid held high.
  - Required response:
    - Writes 32'h00A00513 @0 and 32'h00B00593 @4, each imem_wen exactly one cycle.
    - s_ready=0 during each WRITE.
    - done=1, cpu_enable=1, words_loaded=2.
- Bad checksum:
  - Stimulus: same stream with last byte 01.
  - Required response: error=1, cpu_enable=0, done=0, both words still written.
- Oversize and empty programs:
  - Stimulus: header 01 02 (N=513).
  - Required response: ERR right after HDR1, no imem_wen pulse.
  - Stimulus: header 00 00 with checksum 00 00 00 00.
  - Required response: RUN with words_loaded=0 and no writes.
- Throttled stream:
  - Stimulus: s_valid toggling pseudo-randomly, plus a start pulse injected mid-DATA.
  - Required response: byte order preserved; identical writes to the nominal case; mid-session start ignored.
- Reset mid-session:
  - Stimulus: arst asserted after 2 data bytes.
  - Required response: all outputs 0 asynchronously, no write issued. A following start plus the full nominal stream succeeds.
- Restart from RUN:
  - Stimulus: start while in RUN.
  - Required response: cpu_enable falls the next cycle, words_loaded=0, busy=1, and a new load writes from address 0.
